// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_pkg
//  Description : Shared types and defaults for the instruction-memory
//                arbiter. It holds the controller state enum, the enum that
//                tags a read response with its owner, and the default
//                address and data widths.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_mem_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_LD   = 2'd2
  } tag_e;

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/inst_mem_rr_sel.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_rr_sel
//  Description : Grant selection between the fetch port and the loader port.
//                In BOOT only the loader is served. In RUN the loader has
//                priority, but after MAX_LD_BURST consecutive loader grants
//                taken while a fetch waits, the fetch gets one slot.
//  Ports       : clock, reset_n    - clock and async active-low reset
//                run               - 1 when the controller is in RUN
//                if_req / ld_req   - fetch and loader requests
//                if_gnt / ld_gnt   - one-hot (or idle) grants, combinational
//  Revision    : 1.0  initial release
// ============================================================================
module inst_mem_rr_sel
  import mips_mem_pkg::*;
#(
  parameter int MAX_LD_BURST = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  input  logic if_req,
  input  logic ld_req,
  output logic if_gnt,
  output logic ld_gnt
);

  logic [3:0] burst_cnt_q;
  logic [3:0] burst_cnt_d;
  logic       cap_hit;

  // The cap takes effect only while a fetch is actually waiting.
  assign cap_hit = run && if_req && (burst_cnt_q >= 4'(MAX_LD_BURST));

  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (!run) begin
      ld_gnt = ld_req;
    end else if (cap_hit) begin
      if_gnt = 1'b1;
    end else if (ld_req) begin
      ld_gnt = 1'b1;
    end else begin
      if_gnt = if_req;
    end
  end

  // Counts loader grants that pushed a waiting fetch aside. Any cycle
  // without a loader grant starts a fresh burst. Counting is confined to
  // RUN so BOOT traffic cannot pre-load the cap.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!run || !ld_gnt) begin
      burst_cnt_d = 4'd0;
    end else if (if_req && (burst_cnt_q != 4'hF)) begin
      burst_cnt_d = burst_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt_q <= 4'd0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule : inst_mem_rr_sel
`default_nettype wire

// File: rtl/inst_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_arbiter
//  Description : Shares a single-port synchronous instruction memory between
//                the CPU fetch stage and a program loader. Holds the CPU in
//                BOOT until the loader signals ld_done, then arbitrates with
//                a loader burst cap. Reads return one cycle after the grant
//                and are steered to the port that issued them.
//  Ports       : clock, reset_n               - clock, async active-low reset
//                if_req/if_pc/if_gnt          - fetch request side
//                if_rvalid/if_instr/if_misalign - fetch response
//                cpu_stall                    - high while in BOOT
//                ld_req/ld_we/ld_addr/ld_wdata/ld_done/ld_gnt - loader side
//                ld_rvalid/ld_rdata           - loader read-back response
//                mem_address/mem_data/mem_wren/mem_q - memory port
//  Revision    : 1.0  initial release
// ============================================================================
module inst_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_LD_BURST  = 4,
  parameter bit BOOT_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [31:0]       if_pc,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_misalign,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam state_e RESET_STATE = BOOT_ON_RESET ? BOOT : RUN;

  state_e            state_q, state_d;
  tag_e              tag_q, tag_d;
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              run;
  logic              unused_pc_bits;

  // PC bits above the memory depth simply wrap.
  assign unused_pc_bits = &{1'b0, if_pc[31:ADDR_W+2]};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if ((state_q == BOOT) && ld_done) begin
      state_d = RUN;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run       = (state_q == RUN);
    cpu_stall = (state_q == BOOT);
  end

  inst_mem_rr_sel #(
    .MAX_LD_BURST (MAX_LD_BURST)
  ) u_sel (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (run),
    .if_req  (if_req),
    .ld_req  (ld_req),
    .if_gnt  (if_gnt),
    .ld_gnt  (ld_gnt)
  );

  // Memory request side. Address and data are held between accesses; a
  // misaligned fetch is granted but never touches the memory.
  always_comb begin
    tag_d    = TAG_NONE;
    mis_d    = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mem_wren = 1'b0;
    if (ld_gnt) begin
      addr_d = ld_addr;
      if (ld_we) begin
        wdata_d  = ld_wdata;
        mem_wren = 1'b1;
      end else begin
        tag_d = TAG_LD;
      end
    end else if (if_gnt) begin
      tag_d = TAG_IF;
      if (if_pc[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end else begin
        addr_d = if_pc[ADDR_W+1:2];
      end
    end
  end

  assign mem_address = addr_d;
  assign mem_data    = wdata_d;

  // Response side. mem_q is valid in the cycle after the grant, which is
  // exactly when the tag register names the owner; the data is forwarded
  // then and captured so the outputs hold once rvalid drops.
  always_comb begin
    if_rvalid   = (tag_q == TAG_IF);
    ld_rvalid   = (tag_q == TAG_LD);
    if_misalign = if_rvalid && mis_q;
    if_instr_d  = if_instr_q;
    ld_rdata_d  = ld_rdata_q;
    if (if_rvalid) begin
      if_instr_d = mis_q ? '0 : mem_q;
    end
    if (ld_rvalid) begin
      ld_rdata_d = mem_q;
    end
  end

  assign if_instr = if_instr_d;
  assign ld_rdata = ld_rdata_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_q      <= TAG_NONE;
      mis_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_instr_q <= '0;
      ld_rdata_q <= '0;
    end else begin
      tag_q      <= tag_d;
      mis_q      <= mis_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_instr_q <= if_instr_d;
      ld_rdata_q <= ld_rdata_d;
    end
  end

endmodule : inst_mem_arbiter
`default_nettype wire

// File: tb/tb_inst_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_mem_arbiter
//  Description : Directed testbench for inst_mem_arbiter with a behavioural
//                1K x 32 synchronous memory attached to the memory port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inst_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clock;
  logic              reset_n;
  logic              if_req;
  logic [31:0]       if_pc;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_instr;
  logic              if_misalign;
  logic              cpu_stall;
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_done;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  int checks;
  int failures;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  inst_mem_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .MAX_LD_BURST  (4),
    .BOOT_ON_RESET (1'b1)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .if_req      (if_req),
    .if_pc       (if_pc),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_instr    (if_instr),
    .if_misalign (if_misalign),
    .cpu_stall   (cpu_stall),
    .ld_req      (ld_req),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_wdata    (ld_wdata),
    .ld_done     (ld_done),
    .ld_gnt      (ld_gnt),
    .ld_rvalid   (ld_rvalid),
    .ld_rdata    (ld_rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port synchronous RAM: q reflects the address sampled last edge.
  always @(posedge clock) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  function automatic logic [31:0] word_of(input int i);
    if (i == 0) return 32'h2008_0005;
    if (i == 1) return 32'h2009_0003;
    return 32'hC0DE_0000 | (32'(i) * 32'h0000_0101);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem_q    = '0;
    reset_n  = 1'b0;
    if_req   = 1'b0;
    if_pc    = '0;
    ld_req   = 1'b0;
    ld_we    = 1'b0;
    ld_addr  = '0;
    ld_wdata = '0;
    ld_done  = 1'b0;

    // ---- reset state ----
    #2;
    chk("rst_cpu_stall", 32'(cpu_stall), 32'd1);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
    chk("rst_if_instr",  if_instr, 32'd0);
    chk("rst_ld_rdata",  ld_rdata, 32'd0);
    chk("rst_mem_wren",  32'(mem_wren), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // ---- BOOT idle: fetch must never be granted ----
    if_req = 1'b1;
    if_pc  = 32'h4;
    for (int c = 0; c < 4; c++) begin
      tick();
      #2;
      chk("boot_if_gnt",    32'(if_gnt), 32'd0);
      chk("boot_cpu_stall", 32'(cpu_stall), 32'd1);
      chk("boot_mem_wren",  32'(mem_wren), 32'd0);
    end
    if_req = 1'b0;

    // ---- BOOT load of 32 words ----
    for (int i = 0; i < 32; i++) begin
      tick();
      ld_req   = 1'b1;
      ld_we    = 1'b1;
      ld_addr  = 10'(i);
      ld_wdata = word_of(i);
      #2;
      chk("load_ld_gnt",   32'(ld_gnt), 32'd1);
      chk("load_mem_wren", 32'(mem_wren), 32'd1);
      chk("load_mem_addr", 32'(mem_address), 32'(i));
      chk("load_mem_data", mem_data, word_of(i));
    end
    tick();
    ld_req  = 1'b0;
    ld_we   = 1'b0;
    ld_done = 1'b1;
    #2;
    chk("done_cycle_stall", 32'(cpu_stall), 32'd1);
    chk("done_cycle_wren",  32'(mem_wren), 32'd0);
    tick();
    ld_done = 1'b0;
    #2;
    chk("run_cpu_stall", 32'(cpu_stall), 32'd0);

    // ---- single fetch at pc=4 ----
    tick();
    if_req = 1'b1;
    if_pc  = 32'h4;
    #2;
    chk("fetch4_if_gnt",  32'(if_gnt), 32'd1);
    chk("fetch4_mem_addr", 32'(mem_address), 32'd1);
    chk("fetch4_wren",    32'(mem_wren), 32'd0);
    tick();
    if_req = 1'b0;
    #2;
    chk("fetch4_rvalid",   32'(if_rvalid), 32'd1);
    chk("fetch4_instr",    if_instr, 32'h2009_0003);
    chk("fetch4_misalign", 32'(if_misalign), 32'd0);

    // ---- sequential fetch 0x00..0x7C back to back ----
    for (int i = 0; i < 32; i++) begin
      tick();
      if_req = 1'b1;
      if_pc  = 32'(4 * i);
      #2;
      chk("seq_if_gnt",   32'(if_gnt), 32'd1);
      chk("seq_mem_addr", 32'(mem_address), 32'(i));
      if (i > 0) begin
        chk("seq_rvalid", 32'(if_rvalid), 32'd1);
        chk("seq_instr",  if_instr, word_of(i - 1));
      end
    end
    tick();
    if_req = 1'b0;
    #2;
    chk("seq_last_rvalid", 32'(if_rvalid), 32'd1);
    chk("seq_last_instr",  if_instr, word_of(31));
    chk("seq_ld_rvalid",   32'(ld_rvalid), 32'd0);

    // ---- loader read-back in RUN ----
    tick();
    ld_req  = 1'b1;
    ld_we   = 1'b0;
    ld_addr = 10'd5;
    #2;
    chk("rb_ld_gnt",   32'(ld_gnt), 32'd1);
    chk("rb_mem_wren", 32'(mem_wren), 32'd0);
    tick();
    ld_req = 1'b0;
    #2;
    chk("rb_ld_rvalid", 32'(ld_rvalid), 32'd1);
    chk("rb_ld_rdata",  ld_rdata, word_of(5));
    chk("rb_if_rvalid", 32'(if_rvalid), 32'd0);
    tick();
    #2;
    chk("hold_ld_rvalid", 32'(ld_rvalid), 32'd0);
    chk("hold_ld_rdata",  ld_rdata, word_of(5));
    chk("hold_mem_addr",  32'(mem_address), 32'd5);

    // ---- burst cap: LD,LD,LD,LD,IF repeating ----
    for (int k = 0; k < 10; k++) begin
      tick();
      ld_req  = 1'b1;
      ld_we   = 1'b0;
      ld_addr = 10'd3;
      if_req  = 1'b1;
      if_pc   = 32'h0;
      #2;
      chk("burst_ld_gnt", 32'(ld_gnt), (k % 5 == 4) ? 32'd0 : 32'd1);
      chk("burst_if_gnt", 32'(if_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
    end
    tick();
    ld_req = 1'b0;
    if_req = 1'b0;
    #2;
    chk("burst_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("burst_if_instr",  if_instr, word_of(0));

    // ---- misaligned fetch ----
    tick();
    if_req = 1'b1;
    if_pc  = 32'h6;
    #2;
    chk("mis_if_gnt",   32'(if_gnt), 32'd1);
    chk("mis_mem_wren", 32'(mem_wren), 32'd0);
    chk("mis_mem_addr", 32'(mem_address), 32'd0);
    tick();
    if_req  = 1'b0;
    ld_done = 1'b1;
    #2;
    chk("mis_rvalid",   32'(if_rvalid), 32'd1);
    chk("mis_misalign", 32'(if_misalign), 32'd1);
    chk("mis_instr",    if_instr, 32'd0);
    tick();
    ld_done = 1'b0;
    #2;
    chk("run_done_ignored", 32'(cpu_stall), 32'd0);
    chk("mis_clear",        32'(if_misalign), 32'd0);

    // ---- reset during an outstanding loader read ----
    tick();
    ld_req  = 1'b1;
    ld_we   = 1'b0;
    ld_addr = 10'd1;
    #2;
    chk("rstrd_ld_gnt", 32'(ld_gnt), 32'd1);
    #1;
    reset_n = 1'b0;
    ld_req  = 1'b0;
    tick();
    #1;
    chk("rstrd_ld_rvalid", 32'(ld_rvalid), 32'd0);
    chk("rstrd_cpu_stall", 32'(cpu_stall), 32'd1);
    chk("rstrd_ld_rdata",  ld_rdata, 32'd0);
    reset_n = 1'b1;
    tick();
    #2;
    chk("rstrd_boot_stall", 32'(cpu_stall), 32'd1);
    chk("rstrd_ld_rvalid2", 32'(ld_rvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_inst_mem_arbiter
`default_nettype wire
